// File: rtl/decoupler_pkg.sv
// Shared types and constants for the paired-word decoupler.
package decoupler_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoupler_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count; full/empty depend only on state.
// Head reads as zero while empty so the output is defined straight out of reset.
module sync_fifo
  import decoupler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_enq,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_deq,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_enq;
  logic             do_deq;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign do_enq  = i_enq & ~o_full;
  assign do_deq  = i_deq & ~o_empty;
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_enq) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/decoupler.sv
// Splits {high, low} pairs into single elements, low first; a zero low half ends a run and
// drops its high half. Input and output are both FIFO-buffered.
module decoupler
  import decoupler_pkg::*;
#(
  parameter int P_WIDTH = DEF_WIDTH,
  parameter int P_DEPTH = DEF_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [2*P_WIDTH-1:0] i_data,
  input  logic                 i_enq,
  output logic                 o_full,
  output logic [P_WIDTH-1:0]   o_data,
  input  logic                 i_deq,
  output logic                 o_empty
);

  logic [2*P_WIDTH-1:0] in_head;
  logic                 in_empty;
  logic                 pop;
  logic                 push;
  logic [P_WIDTH-1:0]   push_data;
  logic                 out_full;
  logic                 in_v;
  logic                 out_r;
  logic [P_WIDTH-1:0]   lo;
  logic [P_WIDTH-1:0]   hi;
  state_t               state;
  state_t               state_nxt;

  assign in_v = ~in_empty;
  assign out_r = ~out_full;
  assign lo = in_head[P_WIDTH-1:0];
  assign hi = in_head[2*P_WIDTH-1:P_WIDTH];

  sync_fifo #(.WIDTH(2*P_WIDTH), .DEPTH(P_DEPTH)) u_in_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_enq   (i_enq),
    .o_data  (in_head),
    .i_deq   (pop),
    .o_full  (o_full),
    .o_empty (in_empty)
  );

  sync_fifo #(.WIDTH(P_WIDTH), .DEPTH(P_DEPTH)) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (push_data),
    .i_enq   (push),
    .o_data  (o_data),
    .i_deq   (i_deq),
    .o_full  (out_full),
    .o_empty (o_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= LOW;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == LOW) begin
      if (in_v && out_r && (lo != '0)) state_nxt = HIGH;
    end else begin
      if (out_r) state_nxt = LOW;
    end
  end

  // The pair stays at the input head while in HIGH, so hi is always valid there.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    push_data = lo;
    if (state == LOW) begin
      if (in_v && out_r) begin
        push = 1'b1;
        pop  = (lo == '0);
      end
    end else begin
      push_data = hi;
      if (out_r) begin
        push = 1'b1;
        pop  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decoupler.sv
// Scenario tasks for the decoupler; expected elements come from a split/terminator queue model.
module tb_decoupler;

  localparam int W = 32;
  localparam int D = 16;

  logic           clk;
  logic           rst_n;
  logic [2*W-1:0] i_data;
  logic           i_enq;
  logic           o_full;
  logic [W-1:0]   o_data;
  logic           i_deq;
  logic           o_empty;

  int checks;
  int errors;
  logic [W-1:0] exp_q [$];

  decoupler #(.P_WIDTH(W), .P_DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (i_data),
    .i_enq   (i_enq),
    .o_full  (o_full),
    .o_data  (o_data),
    .i_deq   (i_deq),
    .o_empty (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_pair(input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_q.push_back(lo);
    if (lo != '0) exp_q.push_back(hi);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; i_enq = 1'b0; i_deq = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    checks++;
    if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    i_data = {32'h2, 32'h1}; i_enq = 1'b1;
    @(negedge clk);
    i_enq = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_c1_empty: got %b want 1", o_empty); end
    @(negedge clk);
    checks++;
    if (o_empty !== 1'b0 || o_data !== 32'h1)
      begin errors++; $display("FAIL basic_c2_lo: empty %b data %h want 0/1", o_empty, o_data); end
    i_deq = 1'b1;
    @(negedge clk);
    checks++;
    if (o_empty !== 1'b0 || o_data !== 32'h2)
      begin errors++; $display("FAIL basic_hi: empty %b data %h want 0/2", o_empty, o_data); end
    @(negedge clk);
    i_deq = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_drained: got %b want 1", o_empty); end
  endtask

  task automatic test_terminator();
    int got;
    got = 0;
    i_data = {32'h7, 32'h0}; i_enq = 1'b1;
    @(negedge clk);
    i_enq = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_deq = 1'b0;
      if (!o_empty) begin
        got++;
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL term_value: got %h want 0", o_data); end
        i_deq = 1'b1;
      end
      @(negedge clk);
    end
    i_deq = 1'b0;
    checks++;
    if (got != 1) begin errors++; $display("FAIL term_count: got %0d elements want 1", got); end
  endtask

  task automatic test_order();
    exp_q.delete();
    model_pair(32'h0, 32'h5);
    model_pair(32'h9, 32'h8);
    i_data = {32'h0, 32'h5}; i_enq = 1'b1;
    @(negedge clk);
    i_data = {32'h9, 32'h8};
    @(negedge clk);
    i_enq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      i_deq = 1'b0;
      if (!o_empty) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL order_extra: got %h want nothing", o_data);
        end else if (o_data !== exp_q[0]) begin
          errors++; $display("FAIL order_value: got %h want %h", o_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        i_deq = 1'b1;
      end
      @(negedge clk);
    end
    i_deq = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL order_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int sent;
    int rcvd;
    int c;
    exp_q.delete();
    sent = 0;
    c = 0;
    while (sent < 40 && !o_full && c < 200) begin
      i_data = {32'h1000 + 32'(sent), 32'h100 + 32'(sent)};
      i_enq = 1'b1;
      model_pair(i_data[2*W-1:W], i_data[W-1:0]);
      sent++;
      c++;
      @(negedge clk);
    end
    i_enq = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sent != 24) begin errors++; $display("FAIL bp_accepted: got %0d pairs want 24", sent); end
    checks++;
    if (o_full !== 1'b1 || o_empty !== 1'b0)
      begin errors++; $display("FAIL bp_full: full %b empty %b want 1/0", o_full, o_empty); end
    // Attempts while full must vanish without a trace.
    i_data = {32'hDEAD, 32'hBEEF}; i_enq = 1'b1;
    repeat (2) @(negedge clk);
    i_enq = 1'b0;
    rcvd = 0;
    c = 0;
    while ((sent < 40 || exp_q.size() != 0) && c < 500) begin
      i_enq = 1'b0;
      if (sent < 40 && !o_full) begin
        i_data = {32'h1000 + 32'(sent), 32'h100 + 32'(sent)};
        i_enq = 1'b1;
        model_pair(i_data[2*W-1:W], i_data[W-1:0]);
        sent++;
      end
      i_deq = 1'b0;
      if (!o_empty) begin
        rcvd++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got %h want nothing", o_data);
        end else if (o_data !== exp_q[0]) begin
          errors++; $display("FAIL bp_value: got %h want %h", o_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        i_deq = 1'b1;
      end
      c++;
      @(negedge clk);
    end
    i_enq = 1'b0; i_deq = 1'b0;
    checks++;
    if (rcvd != 80) begin errors++; $display("FAIL bp_total: got %0d elements want 80", rcvd); end
    repeat (3) @(negedge clk);
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL bp_leftover: empty %b want 1", o_empty); end
  endtask

  task automatic test_reset_mid();
    int got;
    exp_q.delete();
    i_data = {32'hB, 32'hA}; i_enq = 1'b1;
    @(negedge clk);
    i_enq = 1'b0;
    @(negedge clk);
    checks++;
    if (o_empty !== 1'b0 || o_data !== 32'hA)
      begin errors++; $display("FAIL rst_pre: empty %b data %h want 0/a", o_empty, o_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_data !== '0)
      begin errors++; $display("FAIL rst_async: empty %b full %b data %h want 1/0/0", o_empty, o_full, o_data); end
    @(negedge clk);
    rst_n = 1'b1;
    model_pair(32'hD, 32'hC);
    i_data = {32'hD, 32'hC}; i_enq = 1'b1;
    @(negedge clk);
    i_enq = 1'b0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      i_deq = 1'b0;
      if (!o_empty) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rst_extra: got %h want nothing", o_data);
        end else if (o_data !== exp_q[0]) begin
          errors++; $display("FAIL rst_value: got %h want %h", o_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        i_deq = 1'b1;
      end
      @(negedge clk);
    end
    i_deq = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("FAIL rst_count: got %0d elements want 2", got); end
  endtask

  task automatic test_random();
    int sent;
    int c;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    exp_q.delete();
    sent = 0;
    c = 0;
    while ((sent < 1000 || exp_q.size() != 0) && c < 30000) begin
      i_enq = 1'b0;
      if (sent < 1000 && $urandom_range(1, 0) == 1) begin
        lo = ($urandom_range(9, 0) == 0) ? '0 : ($urandom() | 32'h1);
        hi = ($urandom_range(9, 0) == 0) ? '0 : $urandom();
        i_data = {hi, lo};
        i_enq = 1'b1;
        if (!o_full) begin
          model_pair(hi, lo);
          sent++;
        end
      end
      i_deq = ($urandom_range(1, 0) == 1);
      if (i_deq && !o_empty) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h want nothing", o_data);
        end else if (o_data !== exp_q[0]) begin
          errors++; $display("FAIL rand_value: got %h want %h", o_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      c++;
      @(negedge clk);
    end
    i_enq = 1'b0; i_deq = 1'b0;
    checks++;
    if (sent != 1000 || exp_q.size() != 0)
      begin errors++; $display("FAIL rand_timeout: sent %0d pending %0d want 1000/0", sent, exp_q.size()); end
    repeat (3) @(negedge clk);
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL rand_leftover: empty %b want 1", o_empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_terminator();
    test_order();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoupler.md
Name: decoupler

Overview:
- Splits each 2*P_WIDTH paired word back into two P_WIDTH elements.
- Low half {[P_WIDTH-1:0]} is emitted first, then high half.
- All-zero P_WIDTH element is the run terminator. A pair whose low half is zero yields exactly one zero element; its high half is discarded.
- Sits between a paired-width stream (e.g. DRAM/merge-tree wide port) and a single-width merger input, buffered by FIFOs on both sides.

Parameters:
P_WIDTH, 128, element width in bits; must be >= 1.
P_DEPTH, 16, depth of each internal FIFO in entries; power of 2, >= 2.

Ports:
i_clk    input   1            clock; all state updates on rising edge
i_rst_n  input   1            asynchronous active-low reset; asserts async, deasserts sync to i_clk
i_data   input   2*P_WIDTH    paired word {high, low}
i_enq    input   1            enqueue i_data; accepted only when o_full=0
o_full   output  1            input FIFO full
o_data   output  P_WIDTH      head of output FIFO, show-ahead; valid while o_empty=0
i_deq    input   1            dequeue head; ignored when o_empty=1
o_empty  output  1            output FIFO empty

Behaviour:
- Reset values (async, i_rst_n=0):
  - o_full=0, o_empty=1, o_data=0.
  - FSM=LOW; all FIFO pointers and counts=0.
  - Contents discarded, including a pair that is half-emitted.
- FIFOs:
  - Synchronous, show-ahead, registered count, P_DEPTH entries.
  - Enq when full is ignored; deq when empty is ignored.
  - Simultaneous enq+deq when neither full nor empty: both take effect, count unchanged.
  - No write-through: data enqueued in cycle N is visible at the head in N+1.
- Let in_v = input FIFO not empty, out_r = output FIFO not full, lo/hi = halves of input head.
- FSM LOW:
  - If in_v & out_r: push lo.
    - If lo==0: pop input, stay LOW (terminator pair, hi dropped).
    - Else: go HIGH, input not popped.
  - Otherwise: hold.
- FSM HIGH:
  - If out_r: push hi, pop input, go LOW.
  - Otherwise: hold.
  - hi==0 with lo!=0 is emitted as a zero terminator, not dropped.
- At most one element is pushed per cycle, so sustained throughput is 1 element/cycle.
- Latency: i_enq at cycle 0 -> lo at o_data, o_empty=0 in cycle 2 -> hi available one cycle after lo is dequeued/pushed (cycle 3 if output not full).
- Ordering: output order strictly follows input order, lo before hi; no reordering, duplication or loss under any backpressure.
- Backpressure:
  - Output full stalls the FSM in its current state without side effects.
  - Input full raises o_full; the upstream must honour it.
- Reset mid-operation (including FSM=HIGH) returns to the reset state; first output after reset comes from a post-reset i_enq.
- No combinational path from i_deq or i_enq to o_full or o_empty.

Decomposition:
- Package decoupler_pkg:
  - localparam LOW/HIGH FSM encodings (1-bit enum typedef).
  - Function clog2 for FIFO pointer width.
  - Default P_WIDTH and P_DEPTH constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports i_clk, i_rst_n, i_data, i_enq, o_data, i_deq, o_full, o_empty).
  - Instantiated twice: input at 2*P_WIDTH, output at P_WIDTH.
- Top level holds only the FSM and the push/pop glue.

Test Plan:
1. Reset, then enq {0x2,0x1} and deq whenever non-empty -> o_empty falls at cycle 2 with o_data=0x1; next element 0x2; then o_empty=1.
2. Enq {0x7,0x0} -> exactly one output element 0x0; o_empty=1 afterward, 0x7 never appears.
3. Enq {0x0,0x5} then {0x9,0x8} -> outputs in order 0x5, 0x0, 0x8, 0x9.
4. Enq 40 distinct nonzero pairs with i_deq=0 -> output holds 16 elements, input fills and o_full=1; extra i_enq while full ignored; then deq continuously -> all 80 elements in order, none lost or duplicated.
5. Enq {0xB,0xA}, deq 0xA so FSM=HIGH, pulse i_rst_n=0 for 1 cycle asynchronously mid-cycle -> o_empty=1, o_full=0, o_data=0 immediately; after release and enq {0xD,0xC} -> outputs 0xC, 0xD only.
6. Random enq/deq streams (50% duty each side), 1000 pairs with ~10% zero low halves -> output matches scoreboard model of the split/terminator rule exactly.
